// File: rtl/keypad_scan_encoder_if.sv
// Key handshake bundle between the keypad scanner and its consumer.
// The master offers pressed_index with key_valid; the slave accepts with key_ready.
interface keypad_scan_encoder_if;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] pressed_index;

    modport master (
        output key_valid,
        output pressed_index,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  pressed_index,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner with debounce and a valid/ready key offer.
// Define KB_MULTI_KEY_REJECT_EN to discard presses with two or more low rows.
module keypad_scan_encoder #(
    parameter int unsigned DEBOUNCE_CNT = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_clk,
    input  logic                  en,
    input  logic [3:0]            keyboard_row,
    output logic [3:0]            keyboard_col,
    keypad_scan_encoder_if.master key_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DEBOUNCE,
        S_OFFER,
        S_RELEASE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       latch_q, latch_d;
    logic [3:0]       idx_q, idx_d;
    logic             valid_q, valid_d;

    logic [2:0]       scan_sync_q;
    logic [3:0]       row_s1_q, row_s2_q;
    logic             tick;
    logic             rows_idle;

    // Lowest-numbered low row wins when several rows are low.
    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] res;
        res = 2'd0;
        if (!r[0]) begin
            res = 2'd0;
        end else if (!r[1]) begin
            res = 2'd1;
        end else if (!r[2]) begin
            res = 2'd2;
        end else if (!r[3]) begin
            res = 2'd3;
        end
        return res;
    endfunction

    function automatic logic multi_low(input logic [3:0] r);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~r[i]};
        end
        return (n >= 3'd2);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
    endfunction

    // Slow-domain inputs: two flops to settle, a third for scan_clk edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_sync_q <= 3'b000;
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
        end else begin
            scan_sync_q <= {scan_sync_q[1:0], scan_clk};
            row_s1_q    <= keyboard_row;
            row_s2_q    <= row_s1_q;
        end
    end

    assign tick      = scan_sync_q[1] & ~scan_sync_q[2];
    assign rows_idle = (row_s2_q == 4'b1111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= CNT_ZERO;
            latch_q <= 4'b1111;
            idx_q   <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        idx_d   = idx_q;
        valid_d = valid_q;

        // Disable wins over everything, including a coincident tick.
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_SCAN;
                    ptr_d   = 2'd0;
                    cnt_d   = CNT_ZERO;
                    valid_d = 1'b0;
                end
                S_SCAN: begin
                    if (tick) begin
                        if (rows_idle) begin
                            ptr_d = ptr_q + 2'd1;
                        end else begin
                            latch_d = row_s2_q;
                            cnt_d   = CNT_ONE;
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (cnt_q >= CNT_MAX) begin
                        cnt_d = CNT_ZERO;
`ifdef KB_MULTI_KEY_REJECT_EN
                        if (multi_low(latch_q)) begin
                            state_d = S_RELEASE;
                        end else begin
                            idx_d   = {ptr_q, low_row(latch_q)};
                            valid_d = 1'b1;
                            state_d = S_OFFER;
                        end
`else
                        idx_d   = {ptr_q, low_row(latch_q)};
                        valid_d = 1'b1;
                        state_d = S_OFFER;
`endif
                    end else if (tick) begin
                        if (row_s2_q == latch_q) begin
                            cnt_d = cnt_inc(cnt_q);
                        end else begin
                            cnt_d   = CNT_ZERO;
                            state_d = S_SCAN;
                        end
                    end
                end
                S_OFFER: begin
                    valid_d = 1'b1;
                    if (key_if.key_ready) begin
                        valid_d = 1'b0;
                        cnt_d   = CNT_ZERO;
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (cnt_q >= CNT_MAX) begin
                        ptr_d   = ptr_q + 2'd1;
                        cnt_d   = CNT_ZERO;
                        state_d = S_SCAN;
                    end else if (tick) begin
                        cnt_d = rows_idle ? cnt_inc(cnt_q) : CNT_ZERO;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    logic unused_multi;
    assign unused_multi = multi_low(latch_q);

    assign keyboard_col         = (state_q == S_IDLE) ? 4'b1111
                                                      : ~(4'b0001 << ptr_q);
    assign key_if.key_valid     = valid_q;
    assign key_if.pressed_index = idx_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with a keypad matrix model
// and a scoreboard of expected key indices.
module tb_keypad_scan_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_clk = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  keyboard_row;
    logic [3:0]  keyboard_col;
    logic [15:0] press = '0;

    int checks = 0;
    int errors = 0;
    int valid_rises = 0;
    int valid_hi = 0;
    logic valid_prev = 1'b0;
    logic [3:0] exp_q[$];

    keypad_scan_encoder_if kif ();

    keypad_scan_encoder #(
        .DEBOUNCE_CNT(3),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scan_clk(scan_clk),
        .en(en),
        .keyboard_row(keyboard_row),
        .keyboard_col(keyboard_col),
        .key_if(kif.master)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low when its column is driven.
    always_comb begin
        keyboard_row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (press[c*4+r] && !keyboard_col[c]) keyboard_row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1 scan_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1 scan_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [15:0] key(input int c, input int r);
        logic [15:0] v;
        v = '0;
        v[c*4+r] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
        end else begin
            if (kif.key_valid) begin
                valid_hi++;
                if (!valid_prev) valid_rises++;
            end
            valid_prev = kif.key_valid;
            if (kif.key_valid && kif.key_ready) begin
                chk("xfer_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("xfer_index", 32'(kif.pressed_index), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int r0;
        int h0;
        int n;
        kif.key_ready = 1'b0;

        // Reset with scan clock running
        ticks(3);
        chk("rst_col", 32'(keyboard_col), 32'hF);
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_index", 32'(kif.pressed_index), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_col", 32'(keyboard_col), 32'hF);

        // Single key col2/row1, consumer not ready
        en = 1'b1;
        @(posedge clk); #1;
        chk("scan_start_col", 32'(keyboard_col), 32'hE);
        press = key(2, 1);
        ticks(6);
        chk("t2_valid", 32'(kif.key_valid), 1);
        chk("t2_index", 32'(kif.pressed_index), 32'h9);
        ticks(3);
        chk("t2_valid_hold", 32'(kif.key_valid), 1);
        chk("t2_index_hold", 32'(kif.pressed_index), 32'h9);
        exp_q.push_back(4'h9);
        kif.key_ready = 1'b1;
        @(posedge clk); #1;
        kif.key_ready = 1'b0;
        chk("t2_valid_drop", 32'(kif.key_valid), 0);
        press = '0;
        ticks(4);

        // Bounce on col0/row3
        n = 0;
        while (keyboard_col != 4'hE && n < 8) begin
            tick();
            n++;
        end
        chk("t3_reach_col0", 32'(keyboard_col), 32'hE);
        r0 = valid_rises;
        press = key(0, 3);
        tick();
        press = '0;
        tick();
        chk("t3_resume_col0", 32'(keyboard_col), 32'hE);
        ticks(6);
        chk("t3_no_offer", 32'(valid_rises - r0), 0);

        // Held key with ready high: one short offer per press
        r0 = valid_rises;
        h0 = valid_hi;
        kif.key_ready = 1'b1;
        exp_q.push_back(4'hC);
        press = key(3, 0);
        ticks(20);
        chk("t4_one_offer", 32'(valid_rises - r0), 1);
        chk("t4_one_cycle", 32'(valid_hi - h0), 1);
        press = '0;
        ticks(3);
        exp_q.push_back(4'hC);
        press = key(3, 0);
        ticks(12);
        chk("t4_second_offer", 32'(valid_rises - r0), 2);
        press = '0;
        ticks(4);

        // en dropped while an offer is pending
        kif.key_ready = 1'b0;
        press = key(1, 2);
        n = 0;
        while (!kif.key_valid && n < 12) begin
            tick();
            n++;
        end
        chk("t5_valid", 32'(kif.key_valid), 1);
        chk("t5_index", 32'(kif.pressed_index), 32'h6);
        en = 1'b0;
        @(posedge clk); #1;
        chk("t5_valid_off", 32'(kif.key_valid), 0);
        chk("t5_col_off", 32'(keyboard_col), 32'hF);
        press = '0;
        ticks(2);
        en = 1'b1;
        @(posedge clk); #1;
        chk("t5_restart_col", 32'(keyboard_col), 32'hE);

        // Two rows low on col1
        r0 = valid_rises;
        kif.key_ready = 1'b1;
        press = key(1, 0) | key(1, 2);
`ifdef KB_MULTI_KEY_REJECT_EN
        ticks(10);
        chk("t6_rejected", 32'(valid_rises - r0), 0);
`else
        exp_q.push_back(4'h4);
        ticks(10);
        chk("t6_accepted", 32'(valid_rises - r0), 1);
`endif
        press = '0;
        ticks(4);
        chk("end_valid", 32'(kif.key_valid), 0);
        chk("end_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
